multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Moore/Mealy FSM that sequences the multi-cycle RV32I datapath. It consumes opcode, f3, f7 and the ALU zero flag from the datapath. It drives every datapath select and write-enable. One instruction spans 3–5 cycles and always starts in FETCH.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an unknown opcode/funct enters sticky ERROR; 0: it is treated as a NOP and the FSM returns to FETCH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; 0 forces state FETCH
opcode  in  7  instruction[6:0]
f3  in  3  instruction[14:12]
f7  in  7  instruction[31:25]
zero  in  1  ALU zero flag (combinational, current cycle)
adr_src  out  1  memory address: 0 = PC, 1 = result
mem_write, ir_write, reg_write, pc_write, old_pc_write  out  1 each  write enables
imm_src  out  3  0=I, 1=S, 2=B, 3=J, 4=U
alu_src_a  out  2  0=PC, 1=oldPC, 2=A
alu_src_b  out  2  0=B, 1=imm, 2=const 4
alu_function  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT, 5=SLTU, 6=XOR
result_src  out  2  0=ALUOut reg, 1=MDR, 2=ALU (comb), 3=imm
illegal  out  1  high while in ERROR

Behaviour:
- Reset:
  - While reset=0, state=FETCH and all enables=0.
  - illegal=0.
  - Selects are don't-care and are driven to 0.
- Unlisted outputs in any state are 0.
- FETCH: adr_src=0, ir_write=1, old_pc_write=1, a=0, b=2, ADD, result_src=2, pc_write=1 -> DECODE.
- DECODE: a=1, b=1, imm_src=B, ADD. ALUOut latches the branch target.
- DECODE dispatch by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL_LINK
  - 1100111 -> JALR_LINK
  - 0110111 -> LUI
  - anything else -> ERROR or FETCH, per TRAP_ON_ILLEGAL
- EXEC_R: a=2, b=0, function from {f7[30], f3}:
  - add=ADD, sub(f7=0100000, f3=000)=SUB
  - and=AND, or=OR, xor=XOR, slt=SLT, sltu=SLTU
  - f7 other than 0000000/0100000 is illegal
  - -> ALU_WB
- EXEC_I: a=2, b=1, imm_src=I.
  - Function from f3: addi, slti, sltiu, xori, ori, andi. Shifts are illegal.
  - -> ALU_WB
- ALU_WB: result_src=0, reg_write=1 -> FETCH.
- MEM_ADDR: a=2, b=1, ADD. imm_src=I for loads, S for stores.
  - Load -> MEM_READ; store -> MEM_WRITE.
- MEM_READ: adr_src=1, result_src=0 -> MEM_WB.
- MEM_WB: result_src=1, reg_write=1 -> FETCH.
- MEM_WRITE: adr_src=1, result_src=0, mem_write=1 -> FETCH.
- BRANCH: a=2, b=0, result_src=0 (target from DECODE). pc_write is combinational on zero:
  - beq: SUB, taken=zero
  - bne: SUB, taken=!zero
  - blt: SLT, taken=!zero
  - bge: SLT, taken=zero
  - bltu: SLTU, taken=!zero
  - bgeu: SLTU, taken=zero
  - f3 010/011 is illegal
  - -> FETCH
- JAL_LINK: a=1, b=2, ADD, result_src=2, reg_write=1 (rd=oldPC+4) -> JAL_PC.
- JAL_PC: a=1, b=1, imm_src=J, ADD, result_src=2, pc_write=1 -> FETCH.
- JALR_LINK: same outputs as JAL_LINK -> JALR_PC.
- JALR_PC: a=2, b=1, imm_src=I, ADD, result_src=2, pc_write=1 -> FETCH.
  - Uses A latched before the link write, so rd==rs1 is safe.
- LUI: imm_src=U, result_src=3, reg_write=1 -> FETCH.
- ERROR: all enables 0, illegal=1. Sticky until reset.
- Latencies (cycles): R/I/LUI-path 4 (LUI 3), load 5, store 4, branch 3, jal/jalr 4.
- Reset asserted mid-instruction aborts it. No partial writes occur after the asserting edge.
- Write-enables never assert in two consecutive cycles for the same instruction except as listed.

Test Plan:
- Reset low 3 cycles, release -> FETCH outputs: ir_write=1, pc_write=1, old_pc_write=1, alu_src_b=2; next cycle DECODE: alu_src_a=1, imm_src=2.
- opcode 0110011, f3=000, f7=0100000 -> states FETCH, DECODE, EXEC_R (alu_function=1), ALU_WB (reg_write=1, result_src=0), then FETCH.
- lw (0000011) -> MEM_ADDR imm_src=0; MEM_READ adr_src=1; MEM_WB result_src=1, reg_write=1; total 5 cycles. sw (0100011) -> MEM_WRITE mem_write=1, imm_src=1, 4 cycles.
- Branches:
  - beq with zero=1 -> pc_write=1 in BRANCH.
  - beq with zero=0 -> pc_write=0.
  - bge with zero=0 -> pc_write=0, alu_function=4.
  - Toggle zero within BRANCH -> pc_write follows zero combinationally.
- jalr rd==rs1: JALR_LINK reg_write=1, result_src=2; JALR_PC alu_src_a=2, imm_src=0, pc_write=1.
- opcode 1111111 with TRAP_ON_ILLEGAL=1 -> ERROR, illegal=1, all enables 0 for 10 cycles; reset asserted -> illegal=0, FETCH.
- With TRAP_ON_ILLEGAL=0 -> back to FETCH after DECODE.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath: sequences fetch, decode and
// per-class execute/memory/writeback steps and drives every select and enable.
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       old_pc_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_function,
    output logic [1:0] result_src,
    output logic       illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_SLTU = 3'd5;
    localparam logic [2:0] ALU_XOR  = 3'd6;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
        S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH,
        S_JAL_LINK, S_JAL_PC, S_JALR_LINK, S_JALR_PC, S_LUI, S_ERROR
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_legal;
    logic [2:0] w_opFn;
    logic [2:0] w_branchFn;
    logic       w_branchTaken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Full legality is resolved in DECODE so no illegal op ever reaches a write step.
    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            OP_R:      w_legal = ((f7 == 7'b0000000) && (f3 != 3'b001) && (f3 != 3'b101)) ||
                                 ((f7 == 7'b0100000) && (f3 == 3'b000));
            OP_I:      w_legal = (f3 != 3'b001) && (f3 != 3'b101);
            OP_BRANCH: w_legal = (f3 != 3'b010) && (f3 != 3'b011);
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI: w_legal = 1'b1;
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_opFn = ALU_ADD;
        case (f3)
            3'b000:  w_opFn = ((opcode == OP_R) && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  w_opFn = ALU_SLT;
            3'b011:  w_opFn = ALU_SLTU;
            3'b100:  w_opFn = ALU_XOR;
            3'b110:  w_opFn = ALU_OR;
            3'b111:  w_opFn = ALU_AND;
            default: w_opFn = ALU_ADD;
        endcase
    end

    // beq/bge/bgeu branch when the comparison result is zero, the others when non-zero.
    always_comb begin
        w_branchFn = ALU_SUB;
        case (f3[2:1])
            2'b10:   w_branchFn = ALU_SLT;
            2'b11:   w_branchFn = ALU_SLTU;
            default: w_branchFn = ALU_SUB;
        endcase
        w_branchTaken = zero ^ (f3[2] ^ f3[0]);
    end

    always_comb begin
        w_next       = r_state;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        old_pc_write = 1'b0;
        imm_src      = 3'd0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_function = ALU_ADD;
        result_src   = 2'd0;
        illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_write     = 1'b1;
                old_pc_write = 1'b1;
                pc_write     = 1'b1;
                alu_src_b    = 2'd2;
                result_src   = 2'd2;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = 3'd2;
                if (!w_legal) begin
                    w_next = TRAP_ON_ILLEGAL ? S_ERROR : S_FETCH;
                end else begin
                    case (opcode)
                        OP_R:              w_next = S_EXEC_R;
                        OP_I:              w_next = S_EXEC_I;
                        OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                        OP_BRANCH:         w_next = S_BRANCH;
                        OP_JAL:            w_next = S_JAL_LINK;
                        OP_JALR:           w_next = S_JALR_LINK;
                        default:           w_next = S_LUI;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a    = 2'd2;
                alu_function = w_opFn;
                w_next       = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a    = 2'd2;
                alu_src_b    = 2'd1;
                alu_function = w_opFn;
                w_next       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (opcode == OP_STORE) ? 3'd1 : 3'd0;
                w_next    = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src = 1'b1;
                w_next  = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 2'd2;
                alu_function = w_branchFn;
                pc_write     = w_branchTaken;
                w_next       = S_FETCH;
            end
            S_JAL_LINK, S_JALR_LINK: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                reg_write  = 1'b1;
                w_next     = (r_state == S_JAL_LINK) ? S_JAL_PC : S_JALR_PC;
            end
            S_JAL_PC: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd1;
                imm_src    = 3'd3;
                result_src = 2'd2;
                pc_write   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JALR_PC: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                pc_write   = 1'b1;
                w_next     = S_FETCH;
            end
            S_LUI: begin
                imm_src    = 3'd4;
                result_src = 2'd3;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_ERROR: begin
                illegal = 1'b1;
                w_next  = S_ERROR;
            end
            default: w_next = S_FETCH;
        endcase
        // Holding reset low silences every output immediately, not just after the next edge.
        if (!reset) begin
            w_next       = S_FETCH;
            adr_src      = 1'b0;
            mem_write    = 1'b0;
            ir_write     = 1'b0;
            reg_write    = 1'b0;
            pc_write     = 1'b0;
            old_pc_write = 1'b0;
            imm_src      = 3'd0;
            alu_src_a    = 2'd0;
            alu_src_b    = 2'd0;
            alu_function = ALU_ADD;
            result_src   = 2'd0;
            illegal      = 1'b0;
        end
    end

endmodule
